// File: rtl/float7_pkg.sv
// Shared definitions for the 7-bit float format (4-bit mantissa, 3-bit exponent)
// and a reference decode used by checkers.
package float7_pkg;

   localparam int MW = 4;
   localparam int EW = 3;
   localparam int BW = 11;

   typedef struct packed {
      logic [MW-1:0] m;
      logic [EW-1:0] e;
   } float7_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [BW-1:0] f7_decode(input float7_t f);
      return BW'(f.m) << f.e;
   endfunction

endpackage

// File: rtl/float2int_serial.sv
// Serial decoder from the 7-bit float (M, E) to the integer M << E, one shift per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; a source keeps its data stable until then.
module float2int_serial
   import float7_pkg::*;
#(
   parameter int MW     = float7_pkg::MW,
   parameter int EW     = float7_pkg::EW,
   parameter int BW     = float7_pkg::BW,
   parameter bit STRICT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] in_m,
   input  logic [EW-1:0] in_e,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_b,
   output logic          out_err,
   output logic [1:0]    state_dbg
);

   if (BW < MW + 2**EW - 1) begin : g_bw_check
      $error("float2int_serial: BW too small to hold the largest decoded value");
   end

   state_t        state_q, state_d;
   logic [BW-1:0] acc_q, acc_d;
   logic [EW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [BW-1:0] out_b_q, out_b_d;
   logic          out_err_q, out_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         out_b_q   <= '0;
         out_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         out_b_q   <= out_b_d;
         out_err_q <= out_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = BW'(in_m);
               cnt_d   = in_e;
               err_d   = STRICT & ~in_m[MW-1] & (in_e != '0);
               state_d = (in_e == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - EW'(1);
            if (cnt_q == EW'(1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The result registers load while DONE is entered or held, so they are
   // already valid in the first DONE cycle and frozen during a stall.
   always_comb begin
      out_b_d   = out_b_q;
      out_err_d = out_err_q;
      if (state_d == DONE) begin
         out_b_d   = acc_d;
         out_err_d = err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_b     = out_b_q;
   assign out_err   = out_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_float2int_serial.sv
// Self-checking bench for float2int_serial: directed scenarios, randomized
// scoreboard traffic and an exhaustive encode/decode round trip.
module tb_float2int_serial;
   import float7_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_m;
   logic [2:0]  in_e;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_b;
   logic        out_err;
   logic [1:0]  state_dbg;

   logic        in_ready_ns;
   logic        out_valid_ns;
   logic [10:0] out_b_ns;
   logic        out_err_ns;
   logic [1:0]  state_dbg_ns;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   float2int_serial #(.STRICT(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_m(in_m), .in_e(in_e), .out_valid(out_valid), .out_ready(out_ready),
      .out_b(out_b), .out_err(out_err), .state_dbg(state_dbg)
   );

   float2int_serial #(.STRICT(1'b0)) u_ns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ns),
      .in_m(in_m), .in_e(in_e), .out_valid(out_valid_ns), .out_ready(out_ready),
      .out_b(out_b_ns), .out_err(out_err_ns), .state_dbg(state_dbg_ns)
   );

   // Driver: present one float, wait for acceptance, then wait for the result
   // with out_ready high. lat counts the accept cycle as 1.
   task automatic do_xfer(input logic [3:0] m, input logic [2:0] e, output int lat,
                          output logic [10:0] b, output logic err, output logic err_ns,
                          output bit to);
      int n;
      to = 1'b0; lat = 0; b = '0; err = 1'b0; err_ns = 1'b0;
      in_m = m; in_e = e; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!out_valid) begin to = 1'b1; return; end
      b = out_b; err = out_err; err_ns = out_err_ns;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_m = '0; in_e = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_b !== 11'd0) begin n_fail++; $display("FAIL reset_out_b: got %0d expected 0", out_b); end
      n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
      n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat; logic [10:0] b; logic err, err_ns; bit to;
      do_xfer(4'b1011, 3'd3, lat, b, err, err_ns, to);
      n_checks++;
      if (to || lat != 4 || b !== 11'd88 || err !== 1'b0)
         begin n_fail++; $display("FAIL basic_11e3: got b=%0d err=%b lat=%0d to=%0d expected b=88 err=0 lat=4", b, err, lat, to); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b expected 1", in_ready); end
      do_xfer(4'd15, 3'd7, lat, b, err, err_ns, to);
      n_checks++;
      if (to || lat != 8 || b !== 11'd1920 || err !== 1'b0)
         begin n_fail++; $display("FAIL max_15e7: got b=%0d err=%b lat=%0d expected b=1920 err=0 lat=8", b, err, lat); end
      do_xfer(4'd5, 3'd0, lat, b, err, err_ns, to);
      n_checks++;
      if (to || lat != 1 || b !== 11'd5 || err !== 1'b0)
         begin n_fail++; $display("FAIL e0_5: got b=%0d err=%b lat=%0d expected b=5 err=0 lat=1", b, err, lat); end
   endtask

   task automatic test_strict();
      int lat; logic [10:0] b; logic err, err_ns; bit to;
      do_xfer(4'b0101, 3'd2, lat, b, err, err_ns, to);
      n_checks++;
      if (to || b !== 11'd20 || err !== 1'b1)
         begin n_fail++; $display("FAIL strict_5e2: got b=%0d err=%b expected b=20 err=1", b, err); end
      n_checks++;
      if (err_ns !== 1'b0) begin n_fail++; $display("FAIL nonstrict_5e2: got err=%b expected 0", err_ns); end
      do_xfer(4'd0, 3'd5, lat, b, err, err_ns, to);
      n_checks++;
      if (to || b !== 11'd0 || err !== 1'b1 || err_ns !== 1'b0)
         begin n_fail++; $display("FAIL zero_m_e5: got b=%0d err=%b err_ns=%b expected b=0 err=1 err_ns=0", b, err, err_ns); end
   endtask

   task automatic test_backpressure();
      int n; bit ok;
      in_m = 4'd9; in_e = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_m = 4'd3; in_e = 3'd1;
      n = 0; ok = 1'b1;
      while (!out_valid && n < 20) begin
         if (in_ready) ok = 1'b0;
         @(posedge clk); #1; n++;
      end
      n_checks++;
      if (!out_valid || !ok || n != 4)
         begin n_fail++; $display("FAIL bp_shift: got out_valid=%b ready_clean=%0d wait=%0d expected 1 1 4", out_valid, ok, n); end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_b !== 11'd144 || in_ready !== 1'b0 || out_err !== 1'b0)
            begin n_fail++; $display("FAIL bp_hold%0d: got v=%b b=%0d rdy=%b err=%b expected v=1 b=144 rdy=0 err=0", i, out_valid, out_b, in_ready, out_err); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL bp_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      n_checks++;
      if (!out_valid || out_b !== 11'd6 || n != 2)
         begin n_fail++; $display("FAIL bp_second: got v=%b b=%0d lat=%0d expected v=1 b=6 lat=2", out_valid, out_b, n); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift();
      int lat; logic [10:0] b; logic err, err_ns; bit to; bit pulse;
      in_m = 4'd12; in_e = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL rst_pre_state: got %0d expected 1", state_dbg); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_b !== 11'd0 || out_err !== 1'b0 || state_dbg !== 2'd0)
         begin n_fail++; $display("FAIL rst_async: got rdy=%b v=%b b=%0d err=%b st=%0d expected 1 0 0 0 0", in_ready, out_valid, out_b, out_err, state_dbg); end
      pulse = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (out_valid) pulse = 1'b1; end
      rst = 1'b0;
      repeat (10) begin @(posedge clk); #1; if (out_valid) pulse = 1'b1; end
      n_checks++;
      if (pulse) begin n_fail++; $display("FAIL rst_no_pulse: got out_valid pulse=1 expected 0"); end
      do_xfer(4'd8, 3'd1, lat, b, err, err_ns, to);
      n_checks++;
      if (to || lat != 2 || b !== 11'd16 || err !== 1'b0)
         begin n_fail++; $display("FAIL rst_next: got b=%0d err=%b lat=%0d expected b=16 err=0 lat=2", b, err, lat); end
   endtask

   task automatic test_random();
      logic [11:0] exp_q[$];
      logic [11:0] exp;
      int sent, recv, cyc, bexp;
      bit acc, deq;
      localparam int N = 200;
      sent = 0; recv = 0; cyc = 0;
      in_valid = 1'b0; out_ready = 1'b0;
      while (recv < N && cyc < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && sent < N && $urandom_range(0, 2) != 0) begin
            in_m = 4'($urandom_range(0, 15));
            in_e = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
         end
         n_checks++;
         if (in_ready && out_valid) begin n_fail++; $display("FAIL rnd_excl: got in_ready=1 out_valid=1 expected not both"); end
         acc = in_valid && in_ready;
         deq = out_valid && out_ready;
         if (acc) begin
            bexp = int'(in_m) * (2 ** int'(in_e));
            exp_q.push_back({(in_m < 4'd8) && (in_e != 3'd0), 11'(bexp)});
         end
         if (deq) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_extra: got b=%0d expected no output", out_b);
            end else begin
               exp = exp_q.pop_front();
               if ({out_err, out_b} !== exp)
                  begin n_fail++; $display("FAIL rnd_item%0d: got b=%0d err=%b expected b=%0d err=%b", recv, out_b, out_err, exp[10:0], exp[11]); end
            end
            recv++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin in_valid = 1'b0; sent++; end
      end
      n_checks++;
      if (recv != N || exp_q.size() != 0)
         begin n_fail++; $display("FAIL rnd_drain: got recv=%0d left=%0d expected recv=%0d left=0", recv, exp_q.size(), N); end
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_round_trip();
      int lat; logic [10:0] b; logic err, err_ns; bit to;
      for (int bb = 0; bb < 2048; bb++) begin
         int e_i;
         float7_t f;
         logic [10:0] exp_b, trunc_b;
         e_i = (bb < 16) ? 0 : ($clog2(bb + 1) - 1 - 3);
         f.m = 4'(bb >> e_i);
         f.e = 3'(e_i);
         exp_b = f7_decode(f);
         trunc_b = 11'((bb >> e_i) << e_i);
         do_xfer(f.m, f.e, lat, b, err, err_ns, to);
         n_checks++;
         if (to || b !== exp_b || b !== trunc_b || err !== 1'b0 || lat != e_i + 1)
            begin n_fail++; $display("FAIL round_trip_%0d: got b=%0d err=%b lat=%0d expected b=%0d err=0 lat=%0d", bb, b, err, lat, trunc_b, e_i + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strict();
      test_backpressure();
      test_reset_mid_shift();
      test_random();
      test_round_trip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
